// File: rtl/btn_cond_pkg.sv
// Shared definitions for the push-button conditioner: FSM encoding and counter width.
package btn_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } btn_state_e;

endpackage

// File: rtl/btn_cond_if.sv
// Switch input and conditioned event outputs of one button channel.
interface btn_cond_if;
    logic i_sw;
    logic o_level;
    logic o_press;
    logic o_release;
    logic o_long;
    logic o_rpt;

    modport master (
        output i_sw,
        input  o_level, o_press, o_release, o_long, o_rpt
    );

    modport slave (
        input  i_sw,
        output o_level, o_press, o_release, o_long, o_rpt
    );
endinterface

// File: rtl/btn_cond_sw_sync_deb.sv
// Polarity fix, 2-flop synchronizer and debounce counter producing a clean pressed level.
module sw_sync_deb
    import btn_pkg::*;
#(
    parameter int unsigned DEB_CYC    = 500000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);

    logic             pressed;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;

    assign pressed = i_sw ^ ACTIVE_LOW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            level_q   <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    always_comb begin
        s1_d      = pressed;
        s2_d      = s1_q;
        level_d   = level_q;
        deb_cnt_d = deb_cnt_q;
        if (s2_q == level_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            level_d   = s2_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    // Edge strobes are valid in the cycle before level flips, so the parent can
    // register its pulses on the same edge that updates o_level.
    assign o_level = level_q;
    assign o_rise  = level_d & ~level_q;
    assign o_fall  = ~level_d & level_q;

endmodule

// File: rtl/btn_cond.sv
// Button conditioner top: debounced level plus press/release/long/auto-repeat pulses.
module btn_cond
    import btn_pkg::*;
#(
    parameter int unsigned DEB_CYC    = 500000,
    parameter int unsigned HOLD_CYC   = 50000000,
    parameter int unsigned RPT_CYC    = 10000000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    btn_cond_if.slave   bif
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYC - 1);

    logic             level, rise, fall;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             rpt_q, rpt_d;

    sw_sync_deb #(
        .DEB_CYC    (DEB_CYC),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_sync_deb (
        .clk     (clk),
        .rst     (rst),
        .i_sw    (bif.i_sw),
        .o_level (level),
        .o_rise  (rise),
        .o_fall  (fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            rpt_cnt_q  <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            rpt_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rpt_cnt_q  <= rpt_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            rpt_q      <= rpt_d;
        end
    end

    // Release is checked first in every held state so it wins over long/repeat.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rpt_cnt_d  = rpt_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d    = ST_PRESSED;
                    hold_cnt_d = '0;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                    rpt_cnt_d  = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_REPEAT;
                    hold_cnt_d = '0;
                    rpt_cnt_d  = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (fall) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                    rpt_cnt_d  = '0;
                end else if (rpt_cnt_q == RPT_LAST) begin
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
                rpt_cnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        press_d   = (state_q == ST_IDLE) && rise;
        release_d = (state_q != ST_IDLE) && fall;
        long_d    = (state_q == ST_PRESSED) && !fall && (hold_cnt_q == HOLD_LAST);
        rpt_d     = press_d || long_d ||
                    ((state_q == ST_REPEAT) && !fall && (rpt_cnt_q == RPT_LAST));
    end

    assign bif.o_level   = level;
    assign bif.o_press   = press_q;
    assign bif.o_release = release_q;
    assign bif.o_long    = long_q;
    assign bif.o_rpt     = rpt_q;

endmodule
